regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback and a long-latency unit (divider / load miss path), and keeps a scoreboard of destination registers with long-latency writes outstanding. Sits between writeback/long-latency units and the register file; decode queries it for RAW hazards and the pipeline honours its stall request.

---
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and a
// buffered long-latency result, and tracks long-latency destinations in a busy scoreboard.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pipe_wen_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        ll_valid_i,
  input  logic [4:0]  ll_waddr_i,
  input  logic [31:0] ll_wdata_i,
  output logic        ll_ready_o,
  input  logic        ll_issue_i,
  input  logic [4:0]  ll_issue_rd_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic        busy1_o,
  output logic        busy2_o,
  output logic        stall_req_o,
  output logic        sb_err_o,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic        r_buf_valid;
  logic [4:0]  r_buf_addr;
  logic [31:0] r_buf_data;
  logic        r_rf_src_ll;
  logic [31:0] r_busy;
  logic [3:0]  r_starve_cnt;

  logic        w_sel_pipe;
  logic        w_sel_buf;
  logic        w_ll_accept;
  logic [4:0]  w_sel_addr;
  logic [31:0] w_sel_data;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_busy_next;
  logic        w_issue_err;

  // Long-latency handshake: a transfer happens on a rising edge where ll_valid_i
  // and ll_ready_o are both high; ll_ready_o depends only on registered state.
  assign ll_ready_o = !r_buf_valid;
  assign busy1_o    = r_busy[raddr1_i];
  assign busy2_o    = r_busy[raddr2_i];

  always_comb begin
    w_sel_pipe  = pipe_wen_i;
    w_sel_buf   = !pipe_wen_i && r_buf_valid;
    w_sel_addr  = w_sel_pipe ? pipe_waddr_i : r_buf_addr;
    w_sel_data  = w_sel_pipe ? pipe_wdata_i : r_buf_data;
    w_ll_accept = ll_valid_i && !r_buf_valid;
    w_set_mask  = '0;
    w_clr_mask  = '0;
    if (ll_issue_i && (ll_issue_rd_i != 5'd0)) w_set_mask[ll_issue_rd_i] = 1'b1;
    if (rf_wen_o && r_rf_src_ll)               w_clr_mask[rf_waddr_o]    = 1'b1;
    // Set is applied after clear so a same-cycle set/clear leaves the bit busy.
    w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
    w_issue_err = |(w_set_mask & r_busy & ~w_clr_mask);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf_valid  <= 1'b0;
      r_buf_addr   <= '0;
      r_buf_data   <= '0;
      r_rf_src_ll  <= 1'b0;
      r_busy       <= '0;
      r_starve_cnt <= '0;
      stall_req_o  <= 1'b0;
      sb_err_o     <= 1'b0;
      rf_wen_o     <= 1'b0;
      rf_waddr_o   <= '0;
      rf_wdata_o   <= '0;
    end else begin
      if (w_sel_buf) begin
        r_buf_valid <= 1'b0;
      end else if (w_ll_accept) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= ll_waddr_i;
        r_buf_data  <= ll_wdata_i;
      end

      // Address-0 writes are consumed but never reach the register file.
      rf_wen_o    <= (w_sel_pipe || w_sel_buf) && (w_sel_addr != 5'd0);
      r_rf_src_ll <= w_sel_buf;
      if (w_sel_pipe || w_sel_buf) begin
        rf_waddr_o <= w_sel_addr;
        rf_wdata_o <= w_sel_data;
      end

      r_busy <= w_busy_next;
      if (w_issue_err) sb_err_o <= 1'b1;

      if (w_sel_buf) begin
        r_starve_cnt <= '0;
      end else if (r_buf_valid && pipe_wen_i && (r_starve_cnt != LP_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
      stall_req_o <= (r_starve_cnt == LP_LIMIT);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed expectations checked a tick after each edge.
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pipe_wen_i = 1'b0;
  logic [4:0]  pipe_waddr_i = '0;
  logic [31:0] pipe_wdata_i = '0;
  logic        ll_valid_i = 1'b0;
  logic [4:0]  ll_waddr_i = '0;
  logic [31:0] ll_wdata_i = '0;
  logic        ll_ready_o;
  logic        ll_issue_i = 1'b0;
  logic [4:0]  ll_issue_rd_i = '0;
  logic [4:0]  raddr1_i = '0;
  logic [4:0]  raddr2_i = '0;
  logic        busy1_o;
  logic        busy2_o;
  logic        stall_req_o;
  logic        sb_err_o;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pipe_wen_i(pipe_wen_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
    .ll_valid_i(ll_valid_i), .ll_waddr_i(ll_waddr_i), .ll_wdata_i(ll_wdata_i),
    .ll_ready_o(ll_ready_o),
    .ll_issue_i(ll_issue_i), .ll_issue_rd_i(ll_issue_rd_i),
    .raddr1_i(raddr1_i), .raddr2_i(raddr2_i),
    .busy1_o(busy1_o), .busy2_o(busy2_o),
    .stall_req_o(stall_req_o), .sb_err_o(sb_err_o),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ll_ready_o), 32'd1);
    check({tag, "_busy1"}, 32'(busy1_o), 32'd0);
    check({tag, "_busy2"}, 32'(busy2_o), 32'd0);
    check({tag, "_stall"}, 32'(stall_req_o), 32'd0);
    check({tag, "_sberr"}, 32'(sb_err_o), 32'd0);
    check({tag, "_wen"}, 32'(rf_wen_o), 32'd0);
    check({tag, "_waddr"}, 32'(rf_waddr_o), 32'd0);
    check({tag, "_wdata"}, rf_wdata_o, 32'd0);
  endtask

  initial begin
    // Reset
    raddr1_i = 5'd5;
    raddr2_i = 5'd7;
    #12;
    check_reset_values("rst");
    tick();
    rst_ni = 1'b1;
    tick();

    // Pipeline write, one cycle latency, no scoreboard effect
    pipe_wen_i = 1'b1; pipe_waddr_i = 5'd5; pipe_wdata_i = 32'hDEAD_BEEF;
    tick();
    pipe_wen_i = 1'b0;
    check("pipe_wen", 32'(rf_wen_o), 32'd1);
    check("pipe_addr", 32'(rf_waddr_o), 32'd5);
    check("pipe_data", rf_wdata_o, 32'hDEAD_BEEF);
    check("pipe_busy", 32'(busy1_o), 32'd0);
    tick();
    check("pipe_wen_off", 32'(rf_wen_o), 32'd0);

    // Issue rd=7, then its long-latency result
    ll_issue_i = 1'b1; ll_issue_rd_i = 5'd7;
    tick();
    ll_issue_i = 1'b0;
    raddr1_i = 5'd7;
    #1;
    check("iss7_busy", 32'(busy1_o), 32'd1);
    check("iss7_ready", 32'(ll_ready_o), 32'd1);
    ll_valid_i = 1'b1; ll_waddr_i = 5'd7; ll_wdata_i = 32'h1234_5678;
    tick();
    ll_valid_i = 1'b0;
    check("ll7_ready_lo", 32'(ll_ready_o), 32'd0);
    check("ll7_wen_e0", 32'(rf_wen_o), 32'd0);
    check("ll7_busy_e0", 32'(busy1_o), 32'd1);
    tick();
    check("ll7_wen", 32'(rf_wen_o), 32'd1);
    check("ll7_addr", 32'(rf_waddr_o), 32'd7);
    check("ll7_data", rf_wdata_o, 32'h1234_5678);
    check("ll7_busy_e1", 32'(busy1_o), 32'd1);
    check("ll7_ready_hi", 32'(ll_ready_o), 32'd1);
    tick();
    check("ll7_wen_off", 32'(rf_wen_o), 32'd0);
    check("ll7_busy_clr", 32'(busy1_o), 32'd0);

    // Pipeline has priority over buffered write to 9
    ll_valid_i = 1'b1; ll_waddr_i = 5'd9; ll_wdata_i = 32'h0000_0099;
    tick();
    ll_valid_i = 1'b0;
    pipe_wen_i = 1'b1; pipe_waddr_i = 5'd3; pipe_wdata_i = 32'h0000_0033;
    tick();
    pipe_wen_i = 1'b0;
    check("prio_addr3", 32'(rf_waddr_o), 32'd3);
    check("prio_data3", rf_wdata_o, 32'h33);
    check("prio_ready_lo", 32'(ll_ready_o), 32'd0);
    tick();
    check("prio_wen9", 32'(rf_wen_o), 32'd1);
    check("prio_addr9", 32'(rf_waddr_o), 32'd9);
    check("prio_data9", rf_wdata_o, 32'h99);
    check("prio_ready_hi", 32'(ll_ready_o), 32'd1);
    tick();

    // Starvation: buffered write to 10 blocked for 6 cycles
    ll_valid_i = 1'b1; ll_waddr_i = 5'd10; ll_wdata_i = 32'h0000_00AA;
    tick();
    ll_valid_i = 1'b0;
    pipe_wen_i = 1'b1; pipe_waddr_i = 5'd1;
    for (int i = 0; i < 6; i++) begin
      pipe_wdata_i = 32'(i);
      tick();
      check($sformatf("starve_c%0d", i + 1), 32'(stall_req_o), (i >= 4) ? 32'd1 : 32'd0);
    end
    pipe_wen_i = 1'b0;
    check("starve_ready_lo", 32'(ll_ready_o), 32'd0);
    tick();
    check("starve_commit_wen", 32'(rf_wen_o), 32'd1);
    check("starve_commit_addr", 32'(rf_waddr_o), 32'd10);
    check("starve_stall_hold", 32'(stall_req_o), 32'd1);
    tick();
    check("starve_stall_clr", 32'(stall_req_o), 32'd0);

    // Register 0: no busy bit, dropped write, buffer still drains
    ll_issue_i = 1'b1; ll_issue_rd_i = 5'd0;
    tick();
    ll_issue_i = 1'b0;
    raddr1_i = 5'd0;
    #1;
    check("r0_busy", 32'(busy1_o), 32'd0);
    ll_valid_i = 1'b1; ll_waddr_i = 5'd0; ll_wdata_i = 32'h0000_0055;
    tick();
    ll_valid_i = 1'b0;
    check("r0_ready_lo", 32'(ll_ready_o), 32'd0);
    tick();
    check("r0_wen", 32'(rf_wen_o), 32'd0);
    check("r0_ready_hi", 32'(ll_ready_o), 32'd1);
    tick();
    check("r0_wen_later", 32'(rf_wen_o), 32'd0);

    // Double issue to rd=4
    ll_issue_i = 1'b1; ll_issue_rd_i = 5'd4;
    tick();
    raddr2_i = 5'd4;
    #1;
    check("dbl_err_first", 32'(sb_err_o), 32'd0);
    check("dbl_busy4", 32'(busy2_o), 32'd1);
    tick();
    ll_issue_i = 1'b0;
    check("dbl_err_set", 32'(sb_err_o), 32'd1);
    check("dbl_busy4_kept", 32'(busy2_o), 32'd1);
    tick();
    check("dbl_err_sticky", 32'(sb_err_o), 32'd1);

    // Asynchronous reset mid-cycle with buffer full and busy[4] set
    ll_valid_i = 1'b1; ll_waddr_i = 5'd12; ll_wdata_i = 32'h0000_00CC;
    pipe_wen_i = 1'b1; pipe_waddr_i = 5'd2; pipe_wdata_i = 32'h0000_0077;
    raddr1_i = 5'd12;
    tick();
    ll_valid_i = 1'b0;
    pipe_wen_i = 1'b0;
    check("pre_rst_ready", 32'(ll_ready_o), 32'd0);
    check("pre_rst_wen", 32'(rf_wen_o), 32'd1);
    check("pre_rst_busy4", 32'(busy2_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_values("async");
    tick();
    rst_ni = 1'b1;
    tick();
    check_reset_values("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
